// File: rtl/clk_div_tick.sv
// Programmable clock divider producing a glitch-free divided clock and a period-start tick.
// Optional period counter output is enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_div_tick #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic             pend;
  logic [CNT_W-1:0] pend_val;

  logic             wrap;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] fall_point;
  logic [CNT_W-1:0] coerced_val;

  // Every offer is accepted; the ratio only lands in div_reg at a period boundary.
  assign div_ready = 1'b1;
  assign accept    = div_valid && div_ready;

  always_comb begin
    wrap        = (cnt == (div_reg - CNT_W'(1)));
    cnt_inc     = cnt + CNT_W'(1);
    fall_point  = div_reg - (div_reg >> 1);
    coerced_val = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_reg  <= CNT_W'(DEFAULT_DIV);
      pend     <= 1'b0;
      pend_val <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (en) begin
        if (wrap) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= 1'b1;
          if (pend) begin
            div_reg <= pend_val;
          end
        end else begin
          cnt  <= cnt_inc;
          tick <= 1'b0;
          if (cnt_inc == fall_point) begin
            clk_out <= 1'b0;
          end
        end
      end else begin
        tick <= 1'b0;
      end

      // A load arriving on the wrap edge stays pending for the following boundary.
      if (accept) begin
        pend     <= 1'b1;
        pend_val <= coerced_val;
      end else if (en && wrap && pend) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (en && wrap) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule
